ram_cmd_master: RTL and testbench

Command initiator for the dual-address synchronous RAM: it turns single host read/write requests into the RAM's 10-bit command-word sequence on its rx_valid/din input. It then collects the read byte returned on tx_valid/dout. It sits between a host-side request source (bus bridge or test sequencer) and the RAM, which makes it the driving end of the RAM command interface. It optionally skips redundant address commands and bounds every read with a timeout.

---
 rtl/ram_cmd_pkg.sv | 26 ++
 rtl/ram_cmd_timeout.sv | 32 +++
 rtl/ram_cmd_master.sv | 139 +++++++++++++
 tb/tb_ram_cmd_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_cmd_pkg.sv
// ram_cmd_pkg: shared widths, opcodes and FSM encoding for the RAM command master
package ram_cmd_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_CMD,
        S_RD_WAIT
    } state_e;

    function automatic logic [CMD_W-1:0] cmd_word(input logic [1:0] op, input logic [DATA_W-1:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/ram_cmd_timeout.sv
// ram_cmd_timeout: counts read-wait cycles without a RAM reply and flags when the limit is reached
module ram_cmd_timeout
    import ram_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = cnt_q == CNT_W'(TIMEOUT);

    // Clear on entry to the wait, count missed cycles, hold once the limit is hit
    always_comb begin
        cnt_d = clear ? '0 : (run && !expired) ? cnt_q + 1'b1 : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_cmd_master.sv
// ram_cmd_master: turns host read/write requests into RAM command words and collects read data
module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          ADDR_CACHE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_din,
    input  logic              ram_tx_valid,
    input  logic [DATA_W-1:0] ram_dout
);

    state_e            state_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wr_addr_q, rd_addr_q;
    logic              wr_addr_ok_q, rd_addr_ok_q;
    logic              cmd_valid_q;
    logic [CMD_W-1:0]  cmd_din_q;
    logic              resp_valid_q, resp_we_q, resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              wr_hit, rd_hit, tmo_expired;

    assign req_ready  = state_q == S_IDLE;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_din    = cmd_din_q;
    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // A hit means the RAM pointer already holds this address, so its address word can be skipped
    assign wr_hit = ADDR_CACHE && wr_addr_ok_q && (wr_addr_q == req_addr);
    assign rd_hit = ADDR_CACHE && rd_addr_ok_q && (rd_addr_q == req_addr);

    ram_cmd_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == S_RD_CMD),
        .run    (state_q == S_RD_WAIT && !ram_tx_valid),
        .expired(tmo_expired)
    );

    // Request sequencer: issues command words, completes requests and tracks the RAM address pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        wdata_q     <= req_wdata;
                        cmd_valid_q <= 1'b1;
                        if (req_we && wr_hit) begin
                            state_q   <= S_WR_DATA;
                            cmd_din_q <= cmd_word(CMD_WR_DATA, req_wdata);
                        end else if (req_we) begin
                            state_q      <= S_WR_ADDR;
                            cmd_din_q    <= cmd_word(CMD_WR_ADDR, req_addr);
                            wr_addr_q    <= req_addr;
                            wr_addr_ok_q <= 1'b1;
                        end else if (rd_hit) begin
                            state_q   <= S_RD_CMD;
                            cmd_din_q <= cmd_word(CMD_RD_DATA, '0);
                        end else begin
                            state_q      <= S_RD_ADDR;
                            cmd_din_q    <= cmd_word(CMD_RD_ADDR, req_addr);
                            rd_addr_q    <= req_addr;
                            rd_addr_ok_q <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR: begin
                    state_q   <= S_WR_DATA;
                    cmd_din_q <= cmd_word(CMD_WR_DATA, wdata_q);
                end
                S_WR_DATA: begin
                    state_q      <= S_IDLE;
                    cmd_valid_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_we_q    <= we_q;
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b0;
                end
                S_RD_ADDR: begin
                    state_q   <= S_RD_CMD;
                    cmd_din_q <= cmd_word(CMD_RD_DATA, '0);
                end
                S_RD_CMD: begin
                    state_q     <= S_RD_WAIT;
                    cmd_valid_q <= 1'b0;
                end
                S_RD_WAIT: begin
                    if (ram_tx_valid || tmo_expired) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b1;
                        resp_we_q    <= we_q;
                        resp_data_q  <= ram_tx_valid ? ram_dout : '0;
                        resp_err_q   <= !ram_tx_valid;
                        if (!ram_tx_valid) rd_addr_ok_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// tb_ram_cmd_master: scoreboard bench with a behavioural RAM for the RAM command master
module tb_ram_cmd_master;

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } resp_t;

    logic       clk, rst;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_we, resp_err;
    logic [7:0] resp_data;
    logic       cmd_valid;
    logic [9:0] cmd_din;
    logic       ram_tx_valid;
    logic [7:0] ram_dout;

    logic       nc_req_valid, nc_req_ready, nc_req_we;
    logic [7:0] nc_req_addr, nc_req_wdata;
    logic       nc_resp_valid, nc_resp_we, nc_resp_err;
    logic [7:0] nc_resp_data;
    logic       nc_cmd_valid;
    logic [9:0] nc_cmd_din;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs = 0;
    bit b2b_on = 0;
    int b2b_due = -1;
    resp_t      exp_resp[$];
    logic [9:0] exp_cmd[$];
    logic [9:0] nc_log[$];
    int nc_resp_n = 0;

    logic       mute = 1'b0;
    logic       frc = 1'b0;
    logic [7:0] frc_data = 8'h00;
    logic [7:0] mem [256];
    logic [7:0] wa, ra, m_dout;
    logic       m_tx = 1'b0;

    ram_cmd_master #(.TIMEOUT(4), .ADDR_CACHE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_data(resp_data), .resp_err(resp_err),
        .cmd_valid(cmd_valid), .cmd_din(cmd_din),
        .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
    );

    ram_cmd_master #(.TIMEOUT(4), .ADDR_CACHE(1'b0)) nc (
        .clk(clk), .rst(rst),
        .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_we(nc_req_we),
        .req_addr(nc_req_addr), .req_wdata(nc_req_wdata),
        .resp_valid(nc_resp_valid), .resp_we(nc_resp_we), .resp_data(nc_resp_data), .resp_err(nc_resp_err),
        .cmd_valid(nc_cmd_valid), .cmd_din(nc_cmd_din),
        .ram_tx_valid(1'b0), .ram_dout(8'h00)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural dual-address RAM: data word returned one cycle after the read-data command
    always @(posedge clk) begin
        m_tx <= 1'b0;
        if (cmd_valid) begin
            case (cmd_din[9:8])
                2'b00: wa <= cmd_din[7:0];
                2'b01: mem[wa] <= cmd_din[7:0];
                2'b10: ra <= cmd_din[7:0];
                default: begin
                    m_tx   <= 1'b1;
                    m_dout <= mem[ra];
                end
            endcase
        end
    end

    assign ram_tx_valid = (m_tx && !mute) || frc;
    assign ram_dout     = frc ? frc_data : m_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every command word and completion pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_unexpected", {22'd0, cmd_din}, 32'hFFFF_FFFF);
            end else begin
                chk("cmd_din", {22'd0, cmd_din}, {22'd0, exp_cmd.pop_front()});
            end
        end
        if (resp_valid) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
            end else begin
                resp_t r;
                r = exp_resp.pop_front();
                chk("resp_we", {31'd0, resp_we}, {31'd0, r.we});
                chk("resp_data", {24'd0, resp_data}, {24'd0, r.data});
                chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                chk("resp_cycle", cyc, r.cyc);
                chk("resp_ready", {31'd0, req_ready}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (nc_cmd_valid) nc_log.push_back(nc_cmd_din);
        if (nc_resp_valid) nc_resp_n++;
    end

    // Present a request, wait for the handshake, queue its expected words and response
    task automatic issue(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int ncmd, input logic [9:0] c0, input logic [9:0] c1,
                         input int lat, input logic [7:0] rdata, input bit err);
        int g;
        resp_t r;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        g = 0;
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) begin
            chk("handshake_timeout", 32'(g), 32'd0);
            req_valid = 1'b0;
            return;
        end
        last_hs = cyc;
        if (b2b_on && b2b_due >= 0) chk("b2b_handshake_cycle", cyc, b2b_due);
        if (b2b_on) b2b_due = cyc + lat;
        exp_cmd.push_back(c0);
        if (ncmd > 1) exp_cmd.push_back(c1);
        if (lat != 0) begin
            r.we   = we;
            r.data = rdata;
            r.err  = err;
            r.cyc  = cyc + lat;
            exp_resp.push_back(r);
        end
        @(negedge clk);
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_resp.size() != 0 || exp_cmd.size() != 0) && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk("drain_resp", exp_resp.size(), 0);
        chk("drain_cmd", exp_cmd.size(), 0);
    endtask

    initial begin
        logic [9:0] nc_exp [4];
        logic [9:0] a;
        nc_exp = '{10'h010, 10'h101, 10'h010, 10'h102};
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        nc_req_valid = 1'b0; nc_req_we = 1'b0; nc_req_addr = 8'h00; nc_req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_din", {22'd0, cmd_din}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_we", {31'd0, resp_we}, 32'd0);
        chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        // write then read back a fresh address
        issue(1, 8'h3C, 8'hA5, 2, 10'h03C, 10'h1A5, 3, 8'h00, 0); req_valid = 1'b0;
        issue(0, 8'h3C, 8'h00, 2, 10'h23C, 10'h300, 4, 8'hA5, 0); req_valid = 1'b0;
        // address cache hits on write and read pointers
        issue(1, 8'h10, 8'h01, 2, 10'h010, 10'h101, 3, 8'h00, 0); req_valid = 1'b0;
        issue(1, 8'h10, 8'h02, 1, 10'h102, 10'h000, 2, 8'h00, 0); req_valid = 1'b0;
        issue(0, 8'h3C, 8'h00, 1, 10'h300, 10'h000, 3, 8'hA5, 0); req_valid = 1'b0;
        issue(1, 8'h55, 8'h66, 2, 10'h055, 10'h166, 3, 8'h00, 0); req_valid = 1'b0;
        drain();
        // read timeout, then the read address must be re-issued
        mute = 1'b1;
        issue(0, 8'h55, 8'h00, 2, 10'h255, 10'h300, 8, 8'h00, 1); req_valid = 1'b0;
        drain();
        mute = 1'b0;
        issue(0, 8'h55, 8'h00, 2, 10'h255, 10'h300, 4, 8'h66, 0); req_valid = 1'b0;
        drain();
        // stray reply while idle changes nothing
        frc_data = 8'h77; frc = 1'b1;
        repeat (2) @(negedge clk);
        frc = 1'b0;
        chk("stray_ready", {31'd0, req_ready}, 32'd1);
        issue(0, 8'h55, 8'h00, 1, 10'h300, 10'h000, 3, 8'h66, 0); req_valid = 1'b0;
        drain();
        // reply on the final timeout cycle wins
        mute = 1'b1;
        issue(0, 8'h3C, 8'h00, 2, 10'h23C, 10'h300, 8, 8'hC3, 0); req_valid = 1'b0;
        while (cyc != last_hs + 7) @(negedge clk);
        frc_data = 8'hC3; frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
        drain();
        mute = 1'b0;
        // back-to-back alternating traffic
        b2b_on = 1'b1; b2b_due = -1;
        issue(1, 8'h00, 8'h11, 2, 10'h000, 10'h111, 3, 8'h00, 0);
        issue(0, 8'h00, 8'h00, 2, 10'h200, 10'h300, 4, 8'h11, 0);
        issue(1, 8'h01, 8'h22, 2, 10'h001, 10'h122, 3, 8'h00, 0);
        issue(0, 8'h01, 8'h00, 2, 10'h201, 10'h300, 4, 8'h22, 0);
        issue(1, 8'h01, 8'h23, 1, 10'h123, 10'h000, 2, 8'h00, 0);
        issue(0, 8'h01, 8'h00, 1, 10'h300, 10'h000, 3, 8'h23, 0);
        issue(1, 8'h03, 8'h44, 2, 10'h003, 10'h144, 3, 8'h00, 0);
        issue(0, 8'h03, 8'h00, 2, 10'h203, 10'h300, 4, 8'h44, 0);
        req_valid = 1'b0; b2b_on = 1'b0;
        drain();
        // reset during RD_CMD aborts the read and clears the cache
        issue(0, 8'h03, 8'h00, 1, 10'h300, 10'h000, 0, 8'h00, 0);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(0, 8'h03, 8'h00, 2, 10'h203, 10'h300, 4, 8'h44, 0); req_valid = 1'b0;
        issue(1, 8'h03, 8'h55, 2, 10'h003, 10'h155, 3, 8'h00, 0); req_valid = 1'b0;
        drain();
        // without the cache every write re-sends its address
        for (int k = 0; k < 2; k++) begin
            nc_req_valid = 1'b1; nc_req_we = 1'b1; nc_req_addr = 8'h10; nc_req_wdata = 8'(k + 1);
            @(negedge clk);
            nc_req_valid = 1'b0; nc_req_wdata = 8'hEE;
            repeat (4) @(negedge clk);
        end
        chk("nc_cmd_count", nc_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a = (i < nc_log.size()) ? nc_log[i] : 10'h3FF;
            chk("nc_cmd_din", {22'd0, a}, {22'd0, nc_exp[i]});
        end
        chk("nc_resp_count", nc_resp_n, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
